mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I-subset datapath (lw, sw, beq, I-type ALU, R-type, jal).
//  Replaces the single-cycle controller when instruction and data share one memory port.
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
//  Drives datapath mux selects, write enables and alu_control.
//  Stalls on a memory ready handshake and traps on illegal opcodes or memory timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max consecutive cycles waiting on mem_ready before trapping; 0 disables watchdog
//  TMO_W           $clog2(TIMEOUT_CYCLES+1)  watchdog counter width (derived, localparam)
// PORTS
//  clk            in   1  system clock; all state updates on rising edge
//  srst           in   1  synchronous active-high reset
//  op             in   7  instr[6:0] from instruction register
//  funct3         in   3  instr[14:12]
//  funct7b5       in   1  instr[30]
//  zero           in   1  ALU zero flag
//  mem_ready      in   1  shared memory has completed current read/write this cycle
//  pc_write       out  1  load PC from result bus
//  adr_src        out  1  memory address select: 0=PC, 1=result bus
//  ir_write       out  1  latch fetched word into IR and PC into old_pc
//  mem_w          out  1  memory write request
//  reg_w          out  1  register file write enable
//  result_src     out  2  00=ALUOut reg, 01=read data reg, 10=ALU result
//  alu_src_a      out  2  00=PC, 01=old_pc, 10=rd1
//  alu_src_b      out  2  00=rd2, 01=immediate, 10=constant 4
//  imm_src        out  2  00=I, 01=S, 10=B, 11=J
//  alu_control    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_instr  out  1  sticky trap flag; unknown opcode or memory timeout
//  state_o        out  4  current state encoding (debug/coverage)
// BEHAVIOUR
//  - Moore FSM; outputs decoded combinationally from state.
//    pc_write/ir_write are additionally gated by mem_ready (FETCH) or zero (BEQ).
//  - srst: state<=FETCH, watchdog<=0, illegal_instr<=0.
//    While srst=1, pc_write, ir_write, mem_w and reg_w are forced to 0.
//    srst mid-instruction aborts it; no partial write is issued.
//  - FETCH: adr_src=0, a=00, b=10, add, result_src=10.
//    If mem_ready: ir_write=1, pc_write=1, go to DECODE; else stay.
//  - DECODE: a=01, b=01, add (branch target into ALUOut); imm_src from op.
//    Next state: lw/sw->MEMADR, R->EXECR, I->EXECI, jal->JAL, beq->BEQ, other->TRAP.
//  - MEMADR: a=10, b=01, add. Next state: lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then go to MEMWB.
//  - MEMWB: result_src=01, reg_w=1, then go to FETCH.
//  - MEMWRITE: adr_src=1, result_src=00, mem_w=1 held every cycle until mem_ready, then go to FETCH.
//  - EXECR: a=10, b=00, ALUOp=funct, then ALUWB.
//  - EXECI: a=10, b=01, ALUOp=funct, then ALUWB.
//  - ALUWB: result_src=00, reg_w=1, then go to FETCH.
//  - JAL: a=01, b=10, add, result_src=00, pc_write=1, then ALUWB (rd<=old_pc+4).
//  - BEQ: a=10, b=00, sub, result_src=00, pc_write=zero, then go to FETCH.
//  - TRAP: all write enables 0, illegal_instr=1; remains in TRAP until srst.
//  - ALU decode: ALUOp add->000, sub->001. Funct decode by funct3:
//    000 -> sub if (op[5] & funct7b5), else add.
//    010 -> slt; 110 -> or; 111 -> and; others -> add.
//  - Watchdog: counts each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0; cleared on state change.
//    Reaching TIMEOUT_CYCLES -> TRAP next cycle. mem_ready on the same cycle wins over timeout.
//  - Cycle counts: lw 5, sw 4, R/I 4, jal 4, beq 3 (with zero-wait memory).
//  - Unused state encodings decode to TRAP.
// STRUCTURE
//  - riscv_pkg: instr_e opcodes, state_e enum, ALUOp enum,
//    alu_control codes, result/alu_src/imm_src select constants.
//  - Sub-module alu_decoder: (alu_op, funct3, op5, funct7b5) -> alu_control, purely combinational.
//  - Top of block: state register, next-state logic, output decode, watchdog counter.
// TESTING
//  1. Zero-wait memory. Run lw, sw, add, addi, jal, beq (taken), beq (not taken) back-to-back.
//     -> State trace cycle counts are 5/4/4/4/4/3/3.
//     -> reg_w pulses exactly once per lw/add/addi/jal; no reg_w for sw/beq.
//  2. lw with mem_ready low for 3 cycles in MEMREAD.
//     -> Stays in MEMREAD for 4 cycles, then one MEMWB cycle with result_src=01, reg_w=1.
//  3. sw with mem_ready low for 2 cycles.
//     -> mem_w=1 for 3 consecutive cycles, adr_src=1 throughout; pc_write=0 in that window.
//  4. op=7'b1111111 in DECODE.
//     -> TRAP next cycle, illegal_instr=1 and held.
//     -> srst pulse returns to FETCH with illegal_instr=0.
//  5. TIMEOUT_CYCLES=8, mem_ready tied 0 in FETCH -> TRAP after exactly 8 stall cycles.
//     Repeat with mem_ready=1 on cycle 8 -> DECODE, no trap.
//  6. srst asserted in MEMWRITE and in ALUWB.
//     -> mem_w and reg_w are 0 that cycle; state_o=FETCH next cycle.
//  7. R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR.
//     addi with instr[30]=1 -> alu_control=000.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, state codes and datapath select constants for mc_control_fsm
// No ports; imported by alu_decoder and mc_control_fsm.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode held in IR.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// rtl/mc_control_fsm_alu_decoder.sv - combinational ALU operation decoder
// Ports: alu_op (add/sub/funct), funct3, op5 (op[5]), funct7b5 in; alu_control out.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // instr[30] only selects sub for R-type; addi ignores it
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I-subset control sequencer with memory watchdog
// Ports: clk, srst; op, funct3, funct7b5, zero, mem_ready in;
//        pc_write, adr_src, ir_write, mem_w, reg_w, result_src, alu_src_a, alu_src_b,
//        imm_src, alu_control, illegal_instr, state_o out.
module mc_control_fsm
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_w,
    output logic       reg_w,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    // A disabled watchdog still needs a 1-bit counter to stay legal.
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [TMO_W-1:0] wdog;
    logic             illegal_q;
    logic             waiting;
    logic             timeout;
    alu_op_e          alu_op;

    assign waiting = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                     && !mem_ready;
    // Counter holds stalls already seen; this stall is the TIMEOUT_CYCLES-th one.
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting
                     && (wdog == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
                        else if (timeout) state_next = S_TRAP;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
                        else if (timeout) state_next = S_TRAP;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
                        else if (timeout) state_next = S_TRAP;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= S_FETCH;
            wdog      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (waiting && (state_next == state)) wdog <= wdog + 1'b1;
            else                                  wdog <= '0;
            if (state_next == S_TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                pc_write  = zero;
            end
            default: ;
        endcase
        // Reset aborts the instruction without any partial write.
        if (srst) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            mem_w    = 1'b0;
            reg_w    = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    assign imm_src       = imm_src_for(op);
    assign illegal_instr = illegal_q;
    assign state_o       = state;

endmodule
